muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide: iterative shift-add multiply and restoring divide on operand magnitudes.
// Latency: done 34 cycles after an accepted start, 2 cycles for divide-by-zero/overflow.
// No backpressure: start is only accepted while idle (busy=0); flush kills the operation.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [63:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] mcand_q;    // multiplicand magnitude or divisor magnitude
    logic        neg_q_q;
    logic        neg_r_q;
    logic        spec_q;
    logic [5:0]  cnt_q;
    logic [31:0] result_q;

    // operand decode, only meaningful while idle
    logic        sgn_a, sgn_b, neg_a, neg_b;
    logic [31:0] mag_a, mag_b;
    logic        div_zero, div_ovf, special;
    logic [31:0] spec_res;
    logic        accept;

    always_comb begin
        sgn_a    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        sgn_b    = op[2] ? ~op[0] : ~op[1];
        neg_a    = sgn_a & a[31];
        neg_b    = sgn_b & b[31];
        mag_a    = neg_a ? (~a + 32'd1) : a;
        mag_b    = neg_b ? (~b + 32'd1) : b;
        div_zero = op[2] & (b == 32'd0);
        div_ovf  = op[2] & ~op[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
        special  = div_zero | div_ovf;
        spec_res = 32'd0;
        if (div_zero)
            spec_res = op[1] ? a : 32'hFFFF_FFFF;
        else if (div_ovf)
            spec_res = op[1] ? 32'd0 : 32'h8000_0000;
    end

    assign accept = (state_q == IDLE) && start && !flush;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = special ? FIX : CALC;
            CALC:    if (cnt_q == 6'd31) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

    // one iteration of each algorithm
    logic [32:0] mul_sum;
    logic [32:0] div_diff;
    logic [63:0] acc_step;

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        div_diff = acc_q[63:31] - {1'b0, mcand_q};
        if (!op_q[2])
            acc_step = {mul_sum, acc_q[31:1]};
        else if (!div_diff[32])
            acc_step = {div_diff[31:0], acc_q[30:0], 1'b1};
        else
            acc_step = {acc_q[62:0], 1'b0};
    end

    // sign fix-up and result select
    logic [63:0] prod;
    logic [31:0] quo, rem, fix_res;

    always_comb begin
        prod = neg_q_q ? (~acc_q + 64'd1) : acc_q;
        quo  = neg_q_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem  = neg_r_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        unique case (op_q)
            3'b000:                 fix_res = prod[31:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[63:32];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rem;
        endcase
        if (spec_q)
            fix_res = acc_q[31:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= 3'd0;
            acc_q    <= 64'd0;
            mcand_q  <= 32'd0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            spec_q   <= 1'b0;
            cnt_q    <= 6'd0;
            result_q <= 32'd0;
        end else if (accept) begin
            op_q    <= op;
            cnt_q   <= 6'd0;
            spec_q  <= special;
            neg_q_q <= neg_a ^ neg_b;
            neg_r_q <= neg_a;
            if (special) begin
                acc_q   <= {32'd0, spec_res};
                mcand_q <= 32'd0;
            end else if (!op[2]) begin
                acc_q   <= {32'd0, mag_b};
                mcand_q <= mag_a;
            end else begin
                acc_q   <= {32'd0, mag_a};
                mcand_q <= mag_b;
            end
        end else if (!flush) begin
            if (state_q == CALC) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + 6'd1;
            end
            if (state_q == FIX)
                result_q <= fix_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit: scoreboard of expected result and done cycle.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = 32'd0;

    // Reference: RV32M semantics straight from signed/unsigned 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int          ix, iy;
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        ix = x;
        iy = y;
        sx = ix;
        sy = iy;
        ux = {32'd0, x};
        uy = {32'd0, y};
        p  = 64'd0;
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ix / iy;
            end
            3'd5: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return ix % iy;
            end
            default: begin
                if (y == 32'd0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bit is_div = (o >= 3'd4);
        bit is_sgn = (o == 3'd4) || (o == 3'd6);
        if (is_div && y == 32'd0) return 2;
        if (is_sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: cycle %0d result %h", cyc, result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (result !== e.res || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done_result: got %h at cycle %0d expected %h at cycle %0d",
                             result, cyc, e.res, e.cyc);
                end
                last_res = e.res;
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int s);
        int   guard = 0;
        exp_t e;
        while (busy && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy %b still high after %0d cycles", busy, guard);
        end
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        s     = cyc;
        e.res = model(o, x, y);
        e.cyc = s + latency(o, x, y);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pick(input bit allow_zero);
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
            2: return allow_zero ? 32'd0 : 32'd7;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int   s;
        exp_t e;

        // Reset state, then a start presented across reset release is taken on the first edge.
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        start = 1'b1;
        op    = 3'b001;
        a     = 32'hFFFF_FFFF;
        b     = 32'h0000_0002;
        rst   = 1'b1;
        e.res = 32'hFFFF_FFFF;
        e.cyc = cyc + 34;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mulh_busy_c1", {31'd0, busy}, 32'd1);
        drain();

        // Directed arithmetic and special cases.
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, s);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, s);
        issue(3'b101, 32'h1234_5678, 32'd0, s);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, s);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, s);
        issue(3'b111, 32'hDEAD_BEEF, 32'd0, s);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, s);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
        drain();

        // Flush mid-multiply: no done, result kept, restart taken right away.
        issue(3'b000, 32'h0001_0003, 32'h0000_0005, s);
        wait_until(s + 10);
        flush = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_result_kept", result, last_res);
        issue(3'b011, 32'hC000_0001, 32'h0000_0100, s);
        drain();

        // Flush and start together in idle: the start is dropped.
        start = 1'b1;
        flush = 1'b1;
        op    = 3'b000;
        a     = 32'd3;
        b     = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);

        // Re-pulsed start during CALC is ignored.
        issue(3'b001, 32'h7654_3210, 32'hF0F0_F0F0, s);
        wait_until(s + 5);
        start = 1'b1;
        op    = 3'b101;
        a     = 32'd100;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // Randomized traffic, back to back.
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick(1'b0), pick(1'b1), s);
        end
        drain();

        // Asynchronous reset mid-operation.
        issue(3'b100, 32'h0BAD_F00D, 32'h0000_0013, s);
        wait_until(s + 20);
        #2;
        rst = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        exp_q.delete();
        last_res = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 3'b110;
        a     = 32'h0000_0064;
        b     = 32'hFFFF_FFF9;
        rst   = 1'b1;
        e.res = 32'h0000_0002;
        e.cyc = cyc + 34;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        repeat (40) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
